// File: rtl/vc_pop_arbiter.sv
// -----------------------------------------------------------------------------
// vc_pop_arbiter
//
// Weighted round-robin scheduler that drains two virtual-channel FIFOs (VC0,
// VC1) into the shared router datapath. Each VC receives a burst credit
// (weight). The granted VC is popped until its credit is used up, and then
// the grant moves to the other VC if that VC can accept a word. Words whose
// destination code is illegal are always popped so that they drain. They are
// then dropped with a one-cycle Error pulse.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   init              configuration window; weights are captured while high
//   weight0/weight1   per-VC burst credit (0 is treated as 1)
//   in0/in1           show-ahead head word of each VC FIFO ([9:8] dest, [7:0] payload)
//   fifo_empty0/1     VC FIFO empty flags
//   dst_almost_full0/1  almost-full flags of the two destination FIFOs
//   pop_0/pop_1       combinational pop strobes to the VC FIFOs (one-hot or idle)
//   data_out          popped word, one cycle after the pop
//   valid_out         data_out carries a legal word
//   Error             popped word had an illegal destination and was dropped
//   idle_out          scheduler is idle
//   active_out        scheduler is arbitrating
// -----------------------------------------------------------------------------
module vc_pop_arbiter #(
   parameter int DATA_W   = 10,
   parameter int WEIGHT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [WEIGHT_W-1:0] weight0,
   input  logic [WEIGHT_W-1:0] weight1,
   input  logic [DATA_W-1:0]   in0,
   input  logic [DATA_W-1:0]   in1,
   input  logic                fifo_empty0,
   input  logic                fifo_empty1,
   input  logic                dst_almost_full0,
   input  logic                dst_almost_full1,
   output logic                pop_0,
   output logic                pop_1,
   output logic [DATA_W-1:0]   data_out,
   output logic                valid_out,
   output logic                Error,
   output logic                idle_out,
   output logic                active_out
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_nx;

   logic [WEIGHT_W-1:0] weight0_q;
   logic [WEIGHT_W-1:0] weight1_q;
   logic [WEIGHT_W-1:0] credit_q;
   logic [WEIGHT_W-1:0] credit_nx;
   logic                grant_q;     // 0 = VC0, 1 = VC1
   logic                grant_nx;

   logic                elig0;
   logic                elig1;
   logic                gnt_elig;
   logic                oth_elig;
   logic                burst_done;
   logic                pop_any;
   logic                pop_sel;     // VC being popped this cycle
   logic [DATA_W-1:0]   pop_word;

   logic [DATA_W-1:0]   data_p1;
   logic                vld_p1;
   logic                err_p1;

   // A zero credit would starve a VC forever, so it is promoted to one.
   function automatic logic [WEIGHT_W-1:0] clamp_weight(input logic [WEIGHT_W-1:0] w);
      return (w == '0) ? WEIGHT_W'(1) : w;
   endfunction

   // Destination codes 10 and 11 are illegal; only the top code bit matters.
   function automatic logic dest_illegal(input logic [DATA_W-1:0] word);
      return word[DATA_W-1];
   endfunction

   // Illegal words bypass backpressure so that they never block the VC.
   function automatic logic vc_eligible(input logic              empty,
                                        input logic [DATA_W-1:0] word,
                                        input logic              af0,
                                        input logic              af1);
      logic af_sel;
      af_sel = word[DATA_W-2] ? af1 : af0;
      return !empty && (dest_illegal(word) || !af_sel);
   endfunction

   always_comb begin
      elig0      = vc_eligible(fifo_empty0, in0, dst_almost_full0, dst_almost_full1);
      elig1      = vc_eligible(fifo_empty1, in1, dst_almost_full0, dst_almost_full1);
      gnt_elig   = grant_q ? elig1 : elig0;
      oth_elig   = grant_q ? elig0 : elig1;
      burst_done = credit_q >= (grant_q ? weight1_q : weight0_q);

      state_nx  = state_q;
      grant_nx  = grant_q;
      credit_nx = credit_q;
      pop_any   = 1'b0;
      pop_sel   = grant_q;

      case (state_q)
         ST_RESET: state_nx = ST_INIT;

         ST_INIT: begin
            if (!init) state_nx = ST_IDLE;
         end

         ST_IDLE: begin
            if (init)
               state_nx = ST_INIT;
            else if (!fifo_empty0 || !fifo_empty1)
               state_nx = ST_ACTIVE;
         end

         ST_ACTIVE: begin
            if (gnt_elig && !burst_done) begin
               pop_any   = 1'b1;
               credit_nx = credit_q + WEIGHT_W'(1);
            end else if (oth_elig) begin
               // Either the burst is spent or the granted VC is blocked.
               pop_any   = 1'b1;
               pop_sel   = !grant_q;
               grant_nx  = !grant_q;
               credit_nx = WEIGHT_W'(1);
            end else if (gnt_elig) begin
               // Burst spent but nobody else wants the datapath: start a new burst.
               pop_any   = 1'b1;
               credit_nx = WEIGHT_W'(1);
            end

            // A pop issued in this cycle still completes when init forces a reconfigure.
            if (init)
               state_nx = ST_INIT;
            else if (fifo_empty0 && fifo_empty1)
               state_nx = ST_IDLE;
         end

         default: state_nx = ST_RESET;
      endcase

      // The FIFOs must never see a pop while reset is asserted.
      if (reset) pop_any = 1'b0;
   end

   assign pop_0    = pop_any && !pop_sel;
   assign pop_1    = pop_any &&  pop_sel;
   assign pop_word = pop_sel ? in1 : in0;

   // ---- stage p1: popped word registered towards the router ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RESET;
         weight0_q <= WEIGHT_W'(1);
         weight1_q <= WEIGHT_W'(1);
         grant_q   <= 1'b0;
         credit_q  <= '0;
         data_p1   <= '0;
         vld_p1    <= 1'b0;
         err_p1    <= 1'b0;
      end else begin
         state_q  <= state_nx;
         grant_q  <= grant_nx;
         credit_q <= credit_nx;
         if (state_q == ST_INIT && init) begin
            weight0_q <= clamp_weight(weight0);
            weight1_q <= clamp_weight(weight1);
         end
         vld_p1 <= pop_any && !dest_illegal(pop_word);
         err_p1 <= pop_any &&  dest_illegal(pop_word);
         // Illegal words still update data_out so the dropped word is visible.
         if (pop_any) data_p1 <= pop_word;
      end
   end

   assign data_out   = data_p1;
   assign valid_out  = vld_p1;
   assign Error      = err_p1;
   assign idle_out   = (state_q == ST_IDLE);
   assign active_out = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_pop_arbiter
//
// Bench for vc_pop_arbiter. The two VC FIFOs are modelled as queues. Each
// cycle a transaction-level reference model of the weighted round-robin
// scheduler predicts the pops and the registered outputs.
// -----------------------------------------------------------------------------
module tb_vc_pop_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init = 1'b0;
   logic [3:0] weight0 = 4'd1;
   logic [3:0] weight1 = 4'd1;
   logic [9:0] in0 = '0;
   logic [9:0] in1 = '0;
   logic       fifo_empty0 = 1'b1;
   logic       fifo_empty1 = 1'b1;
   logic       dst_almost_full0 = 1'b0;
   logic       dst_almost_full1 = 1'b0;
   logic       pop_0, pop_1;
   logic [9:0] data_out;
   logic       valid_out, Error, idle_out, active_out;

   always #5 clk = ~clk;

   vc_pop_arbiter #(.DATA_W(10), .WEIGHT_W(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .init             (init),
      .weight0          (weight0),
      .weight1          (weight1),
      .in0              (in0),
      .in1              (in1),
      .fifo_empty0      (fifo_empty0),
      .fifo_empty1      (fifo_empty1),
      .dst_almost_full0 (dst_almost_full0),
      .dst_almost_full1 (dst_almost_full1),
      .pop_0            (pop_0),
      .pop_1            (pop_1),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .Error            (Error),
      .idle_out         (idle_out),
      .active_out       (active_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // VC FIFO contents; element 0 is the show-ahead head
   logic [9:0] q0[$];
   logic [9:0] q1[$];

   // Observed and predicted vectors:
   // [15] pop_1 [14] pop_0 [13] valid [12] Error [11] idle [10] active [9:0] data
   logic [15:0] obs_v;
   logic [15:0] exp_v;

   // Reference model: scheduler phase, burst accounting, and the word register
   localparam int MD_RESET  = 0;
   localparam int MD_CONFIG = 1;
   localparam int MD_WAIT   = 2;
   localparam int MD_RUN    = 3;
   int         m_mode  = MD_RESET;
   int         m_w[2]  = '{1, 1};
   int         m_cur   = 0;
   int         m_used  = 0;
   int         m_pick  = -1;
   logic [9:0] m_data  = '0;
   bit         m_valid = 1'b0;
   bit         m_err   = 1'b0;

   // One clock cycle. Present the queue heads, capture the DUT outputs,
   // predict them from the model, and advance the model and queues.
   task automatic tick();
      logic [9:0] head[2];
      bit         nonempty[2];
      bit         legal[2];
      bit         elig[2];
      bit         af[2];
      int         o;
      fifo_empty0 = (q0.size() == 0);
      fifo_empty1 = (q1.size() == 0);
      in0 = (q0.size() != 0) ? q0[0] : 10'($urandom);
      in1 = (q1.size() != 0) ? q1[0] : 10'($urandom);
      #1;
      obs_v = {pop_1, pop_0, valid_out, Error, idle_out, active_out, data_out};

      head[0] = in0;           head[1] = in1;
      nonempty[0] = !fifo_empty0; nonempty[1] = !fifo_empty1;
      af[0] = dst_almost_full0; af[1] = dst_almost_full1;
      for (int v = 0; v < 2; v++) begin
         legal[v] = (head[v][9:8] < 2'd2);
         elig[v]  = nonempty[v] && (!legal[v] || !af[head[v][8]]);
      end

      m_pick = -1;
      if (!reset && m_mode == MD_RUN) begin
         o = 1 - m_cur;
         if (elig[m_cur] && m_used < m_w[m_cur]) m_pick = m_cur;
         else if (elig[o])                       m_pick = o;
         else if (elig[m_cur])                   m_pick = m_cur;
      end
      exp_v = {m_pick == 1, m_pick == 0, m_valid, m_err,
               m_mode == MD_WAIT, m_mode == MD_RUN, m_data};

      if (reset) begin
         m_mode = MD_RESET; m_w[0] = 1; m_w[1] = 1; m_cur = 0; m_used = 0;
         m_data = '0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
         if (m_pick >= 0) begin
            m_data  = head[m_pick];
            m_valid = legal[m_pick];
            m_err   = !legal[m_pick];
            // A new burst starts on a VC change or when the old burst is spent
            if (m_pick != m_cur || m_used >= m_w[m_cur]) begin
               m_cur = m_pick; m_used = 1;
            end else begin
               m_used++;
            end
            if (m_pick == 0) void'(q0.pop_front());
            else             void'(q1.pop_front());
         end else begin
            m_valid = 1'b0; m_err = 1'b0;
         end
         case (m_mode)
            MD_RESET:  m_mode = MD_CONFIG;
            MD_CONFIG: begin
               if (init) begin
                  m_w[0] = (weight0 == 4'd0) ? 1 : int'(weight0);
                  m_w[1] = (weight1 == 4'd0) ? 1 : int'(weight1);
               end else begin
                  m_mode = MD_WAIT;
               end
            end
            MD_WAIT: begin
               if (init) m_mode = MD_CONFIG;
               else if (nonempty[0] || nonempty[1]) m_mode = MD_RUN;
            end
            default: begin
               if (init) m_mode = MD_CONFIG;
               else if (!nonempty[0] && !nonempty[1]) m_mode = MD_WAIT;
            end
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset, then a two-cycle init window that loads the given weights.
   task automatic setup(input logic [3:0] w0, input logic [3:0] w1);
      q0.delete(); q1.delete();
      dst_almost_full0 = 1'b0; dst_almost_full1 = 1'b0;
      reset = 1'b1; init = 1'b0;
      tick(); tick();
      reset = 1'b0; init = 1'b1; weight0 = w0; weight1 = w1;
      tick(); tick();
      init = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; init = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (obs_v !== 16'h0000) begin
         n_bad++; $display("FAIL reset_outputs: got %h want %h", obs_v, 16'h0000);
      end
      n_cmp++;
      if (obs_v !== exp_v) begin
         n_bad++; $display("FAIL reset_model: got %h want %h", obs_v, exp_v);
      end
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (obs_v !== 16'h0000) begin
            n_bad++; $display("FAIL reset_release cyc %0d: got %h want %h", c, obs_v, 16'h0000);
         end
      end
   endtask

   task automatic test_wrr();
      int         order[$];
      int         exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      logic [9:0] last_word = '0;
      bit         popped_prev = 1'b0;
      setup(4'd3, 4'd1);
      for (int i = 0; i < 8; i++) begin
         q0.push_back(10'(i));
         q1.push_back(10'h080 | 10'(i));
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL wrr cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (popped_prev) begin
            n_cmp++;
            if ({obs_v[13], obs_v[9:0]} !== {1'b1, last_word}) begin
               n_bad++;
               $display("FAIL wrr_latency cyc %0d: got valid=%b data=%h want valid=1 data=%h",
                        c, obs_v[13], obs_v[9:0], last_word);
            end
         end
         popped_prev = obs_v[14] | obs_v[15];
         last_word   = obs_v[14] ? in0 : in1;
         if (obs_v[14])      order.push_back(0);
         else if (obs_v[15]) order.push_back(1);
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (i >= order.size() || order[i] !== exp_order[i]) begin
            n_bad++;
            $display("FAIL wrr_order pos %0d: got %0d want %0d", i,
                     (i < order.size()) ? order[i] : -1, exp_order[i]);
         end
      end
   endtask

   task automatic test_zero_weight();
      int order[$];
      int exp_order[4] = '{0, 1, 0, 1};
      setup(4'd0, 4'd1);
      for (int i = 0; i < 6; i++) begin
         q0.push_back(10'h010 | 10'(i));
         q1.push_back(10'h020 | 10'(i));
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL zero_weight cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (obs_v[14])      order.push_back(0);
         else if (obs_v[15]) order.push_back(1);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= order.size() || order[i] !== exp_order[i]) begin
            n_bad++;
            $display("FAIL zero_weight_order pos %0d: got %0d want %0d", i,
                     (i < order.size()) ? order[i] : -1, exp_order[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      setup(4'd1, 4'd1);
      q0.push_back(10'h111); q0.push_back(10'h122);
      for (int i = 0; i < 5; i++) q1.push_back(10'h030 | 10'(i));
      dst_almost_full1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c == 5) dst_almost_full1 = 1'b0;
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL backpressure cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (c >= 2) begin
            n_cmp++;
            if (obs_v[15:14] !== ((c == 5) ? 2'b01 : 2'b10)) begin
               n_bad++;
               $display("FAIL backpressure_pops cyc %0d: got %b want %b", c, obs_v[15:14],
                        (c == 5) ? 2'b01 : 2'b10);
            end
         end
      end
   endtask

   task automatic test_illegal();
      setup(4'd1, 4'd1);
      q1.push_back(10'h2A5);
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL illegal cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (c == 2) begin
            n_cmp++;
            if (obs_v[15:14] !== 2'b10) begin
               n_bad++; $display("FAIL illegal_pop: got %b want %b", obs_v[15:14], 2'b10);
            end
         end
         if (c == 3) begin
            n_cmp++;
            if ({obs_v[13], obs_v[12], obs_v[9:0]} !== {1'b0, 1'b1, 10'h2A5}) begin
               n_bad++;
               $display("FAIL illegal_drop: got valid=%b err=%b data=%h want valid=0 err=1 data=2a5",
                        obs_v[13], obs_v[12], obs_v[9:0]);
            end
         end
      end
   endtask

   task automatic test_idle_resume();
      setup(4'd3, 4'd1);
      q0.push_back(10'h041); q0.push_back(10'h042);
      for (int c = 0; c < 8; c++) begin
         if (c == 5) begin
            q0.push_back(10'h043);
            q1.push_back(10'h051);
         end
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL idle_resume cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (c == 4) begin
            n_cmp++;
            if (obs_v[15:14] !== 2'b00) begin
               n_bad++; $display("FAIL idle_nopop: got %b want %b", obs_v[15:14], 2'b00);
            end
         end
         if (c == 5) begin
            n_cmp++;
            if ({obs_v[15:14], obs_v[11]} !== 3'b001) begin
               n_bad++; $display("FAIL idle_flag: got %b want %b", {obs_v[15:14], obs_v[11]}, 3'b001);
            end
         end
         if (c == 6) begin
            n_cmp++;
            if ({obs_v[15:14], obs_v[10]} !== 3'b011) begin
               n_bad++; $display("FAIL resume_credit: got %b want %b", {obs_v[15:14], obs_v[10]}, 3'b011);
            end
         end
         if (c == 7) begin
            n_cmp++;
            if (obs_v[15:14] !== 2'b10) begin
               n_bad++; $display("FAIL resume_switch: got %b want %b", obs_v[15:14], 2'b10);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      setup(4'd1, 4'd1);
      for (int i = 0; i < 6; i++) begin
         q0.push_back(10'h060 | 10'(i));
         q1.push_back(10'h070 | 10'(i));
      end
      for (int c = 0; c < 9; c++) begin
         reset = (c == 4);
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL reset_mid cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
         if (c == 4 || c == 6 || c == 7) begin
            n_cmp++;
            if (obs_v[15:14] !== 2'b00) begin
               n_bad++; $display("FAIL reset_mid_nopop cyc %0d: got %b want %b", c, obs_v[15:14], 2'b00);
            end
         end
         if (c == 5) begin
            n_cmp++;
            if (obs_v !== 16'h0000) begin
               n_bad++; $display("FAIL reset_mid_clear: got %h want %h", obs_v, 16'h0000);
            end
         end
         if (c == 8) begin
            n_cmp++;
            if (obs_v[15:14] !== 2'b01) begin
               n_bad++; $display("FAIL reset_mid_restart: got %b want %b", obs_v[15:14], 2'b01);
            end
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      int         d;
      logic [1:0] code;
      setup(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int c = 0; c < 1500; c++) begin
         for (int v = 0; v < 2; v++) begin
            if ($urandom_range(0, 2) == 0) begin
               d = $urandom_range(0, 7);
               code = (d < 3) ? 2'd0 : (d < 6) ? 2'd1 : (d == 6) ? 2'd2 : 2'd3;
               if (v == 0 && q0.size() < 6) q0.push_back({code, 8'($urandom)});
               if (v == 1 && q1.size() < 6) q1.push_back({code, 8'($urandom)});
            end
         end
         dst_almost_full0 = ($urandom_range(0, 3) == 0);
         dst_almost_full1 = ($urandom_range(0, 3) == 0);
         init  = ($urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 299) == 0);
         if (init) begin
            weight0 = 4'($urandom_range(0, 15));
            weight1 = 4'($urandom_range(0, 15));
         end
         tick();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_bad++; $display("FAIL random cyc %0d: got %h want %h", c, obs_v, exp_v);
         end
      end
      init = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrr();
      test_zero_weight();
      test_backpressure();
      test_illegal();
      test_idle_resume();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
